pipe_ctrl: RTL

Pipeline control unit that drives the 6-bit `stall` bus consumed by every pipeline register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It arbitrates stall requests from ID (load-use) and EX (multi-cycle ops) and sequences a flush on an exception request from MEM. It also runs an EX-hold watchdog and, optionally, performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 36 +++
 rtl/pipe_ctrl_perf.sv | 43 ++++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall bus patterns,
// FSM state encoding and the stall-source selector.
package pipe_ctrl_pkg;

    localparam int STALL_W    = 6;
    localparam int HOLD_CNT_W = 16;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit order, MSB first: WB, MEM, EX, ID, IF, PC
    localparam logic [STALL_W-1:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    localparam logic [STALL_W-1:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
    localparam logic [STALL_W-1:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_EX_HOLD = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ID   = 2'd1,
        SEL_EX   = 2'd2
    } stall_sel_e;

    function automatic logic [STALL_W-1:0] stall_pattern(input stall_sel_e sel);
        case (sel)
            SEL_EX:  stall_pattern = STALL_EX;
            SEL_ID:  stall_pattern = STALL_ID;
            default: stall_pattern = STALL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Performance counter bank for pipe_ctrl; instantiated only when
// PIPE_CTRL_PERF_EN is defined. All counters wrap past all-ones.
module pipe_ctrl_perf #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_freeze,
    input  logic             i_stall_pc,
    input  logic             i_id_sel,
    input  logic             i_ex_enter,
    output logic [CNT_W-1:0] o_perf_stall_cycles,
    output logic [CNT_W-1:0] o_perf_id_events,
    output logic [CNT_W-1:0] o_perf_ex_events
);

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_id_events;
    logic [CNT_W-1:0] r_ex_events;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cycles <= '0;
            r_id_events    <= '0;
            r_ex_events    <= '0;
        end else if (!i_freeze) begin
            if (i_stall_pc) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (i_id_sel) begin
                r_id_events <= r_id_events + CNT_W'(1);
            end
            if (i_ex_enter) begin
                r_ex_events <= r_ex_events + CNT_W'(1);
            end
        end
    end

    assign o_perf_stall_cycles = r_stall_cycles;
    assign o_perf_id_events    = r_id_events;
    assign o_perf_ex_events    = r_ex_events;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with EX-hold watchdog.
// Define PIPE_CTRL_PERF_EN to add the performance counter ports and logic.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_stallreq_from_id,
    input  logic               i_stallreq_from_ex,
    input  logic               i_flush_req,
    input  logic               i_timeout_clr,
    output logic [STALL_W-1:0] o_stall,
    output logic               o_flush,
    output logic               o_stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   o_perf_stall_cycles,
    output logic [CNT_W-1:0]   o_perf_id_events,
    output logic [CNT_W-1:0]   o_perf_ex_events
`endif
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(TIMEOUT);
    localparam logic [HOLD_CNT_W-1:0] HOLD_TRIP  = HOLD_CNT_W'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("pipe_ctrl: TIMEOUT must lie in 2..65535");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_ctrl: CNT_W must be at least 1");
    end

    pipe_state_e           r_state;
    pipe_state_e           w_next_state;
    stall_sel_e            w_sel;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_next;
    logic                  r_stall_timeout;
    logic                  w_timeout_hit;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Requests seen during FLUSH, or alongside a new flush, are dropped outright.
    always_comb begin
        w_next_state = r_state;
        w_sel        = SEL_NONE;

        if (r_state != ST_FLUSH && !i_flush_req) begin
            if (i_stallreq_from_ex) begin
                w_sel = SEL_EX;
            end else if (i_stallreq_from_id) begin
                w_sel = SEL_ID;
            end
        end

        if (i_flush_req) begin
            w_next_state = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_stallreq_from_ex) begin
                        w_next_state = ST_EX_HOLD;
                    end
                end
                ST_EX_HOLD: begin
                    if (!i_stallreq_from_ex) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FLUSH: w_next_state = ST_RUN;
                default:  w_next_state = ST_RUN;
            endcase
        end
    end

    assign o_stall = stall_pattern(w_sel);
    assign o_flush = (r_state == ST_FLUSH);

    // Saturating at TIMEOUT keeps the trip compare from firing twice in one hold.
    always_comb begin
        w_hold_cnt_next = '0;
        if (r_state == ST_EX_HOLD && w_next_state == ST_EX_HOLD) begin
            if (r_hold_cnt == HOLD_LIMIT) begin
                w_hold_cnt_next = r_hold_cnt;
            end else begin
                w_hold_cnt_next = r_hold_cnt + HOLD_CNT_W'(1);
            end
        end
    end

    assign w_timeout_hit = (r_state == ST_EX_HOLD) && (r_hold_cnt == HOLD_TRIP) && i_stallreq_from_ex;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hold_cnt      <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_next;
            if (w_timeout_hit) begin
                r_stall_timeout <= 1'b1;
            end else if (i_timeout_clr) begin
                r_stall_timeout <= 1'b0;
            end
        end
    end

    assign o_stall_timeout = r_stall_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic w_ex_enter;
    logic w_id_sel;

    assign w_ex_enter = (r_state == ST_RUN) && (w_next_state == ST_EX_HOLD);
    assign w_id_sel   = (w_sel == SEL_ID);

    pipe_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_freeze            (r_state == ST_FLUSH),
        .i_stall_pc          (o_stall[0]),
        .i_id_sel            (w_id_sel),
        .i_ex_enter          (w_ex_enter),
        .o_perf_stall_cycles (o_perf_stall_cycles),
        .o_perf_id_events    (o_perf_id_events),
        .o_perf_ex_events    (o_perf_ex_events)
    );
`endif

endmodule
